simmem_release_scheduler: RTL and testbench

// - Decides when each response held in a simmem response bank may be released, and drives that bank's release_en multi-hot.
// - Each reserved bank slot carries an AXI ID and a simulated-latency delay.
// - A slot becomes releasable once all three hold: its delay has elapsed, its response has arrived, and no older slot with the same AXI ID is still pending.
// - One instance per bank: write-response bank and read-data bank.

---
 rtl/simmem_pkg.sv | 32 +++
 rtl/simmem_release_slot.sv | 67 ++++++
 rtl/simmem_release_scheduler.sv | 122 ++++++++++++
 tb/tb_simmem_release_scheduler.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/simmem_pkg.sv
// simmem_pkg: shared types and sizing for the simmem response banks.
//   - WrNumSlots/WrDelayWidth, RdNumSlots/RdDelayWidth: per-bank sizing.
//   - sched_req_t:  schedule request bundle {addr, id, delay}.
//   - slot_state_t: one release-tracking slot {valid, arrived, id, cnt}.
// Struct field widths are taken from the widest bank. Modules default their
// parameters to these values, so the default build has matching widths.
package simmem_pkg;

    localparam int unsigned WrNumSlots   = 16;
    localparam int unsigned WrDelayWidth = 8;
    localparam int unsigned RdNumSlots   = 16;
    localparam int unsigned RdDelayWidth = 8;
    localparam int unsigned AxiNumIds    = 4;
    localparam int unsigned AxiIdW       = $clog2(AxiNumIds);

    localparam int unsigned ReqSlotW  = $clog2((WrNumSlots > RdNumSlots) ? WrNumSlots : RdNumSlots);
    localparam int unsigned ReqDelayW = (WrDelayWidth > RdDelayWidth) ? WrDelayWidth : RdDelayWidth;

    typedef struct packed {
        logic [ReqSlotW-1:0]  addr;
        logic [AxiIdW-1:0]    id;
        logic [ReqDelayW-1:0] delay;
    } sched_req_t;

    typedef struct packed {
        logic                 valid;
        logic                 arrived;
        logic [AxiIdW-1:0]    id;
        logic [ReqDelayW-1:0] cnt;
    } slot_state_t;

endpackage

// File: rtl/simmem_release_slot.sv
// simmem_release_slot: tracking state for one bank slot.
// Holds valid/arrived flags, the AXI ID, the latency down-counter and the
// mask of older same-ID slots, and reports whether the slot may be released.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   i_accept         schedule request accepted into this slot this cycle
//   i_id, i_delay    AXI ID and latency captured on accept
//   i_arrived        bank stored the response for this slot
//   i_older          same-ID valid slots at accept time (already release-masked)
//   i_released       effective release vector of the whole bank
//   i_release_self   this slot is being released this cycle
//   o_valid, o_id    slot is tracked / its AXI ID
//   o_eligible       valid & arrived & counter expired & no older same-ID slot
module simmem_release_slot
    import simmem_pkg::*;
#(
    parameter int unsigned NumSlots = WrNumSlots
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 i_accept,
    input  logic [AxiIdW-1:0]    i_id,
    input  logic [ReqDelayW-1:0] i_delay,
    input  logic                 i_arrived,
    input  logic [NumSlots-1:0]  i_older,
    input  logic [NumSlots-1:0]  i_released,
    input  logic                 i_release_self,
    output logic                 o_valid,
    output logic [AxiIdW-1:0]    o_id,
    output logic                 o_eligible
);

    slot_state_t         r_st;
    logic [NumSlots-1:0] r_older;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_st    <= '0;
            r_older <= '0;
        end else if (i_accept) begin
            // An accept only ever targets an invalid slot, so it cannot
            // coincide with this slot's own release.
            r_st.valid   <= 1'b1;
            r_st.arrived <= i_arrived;
            r_st.id      <= i_id;
            r_st.cnt     <= i_delay;
            r_older      <= i_older & ~i_released;
        end else begin
            r_older <= r_older & ~i_released;
            if (i_release_self) begin
                r_st.valid   <= 1'b0;
                r_st.arrived <= 1'b0;
            end else if (r_st.valid && i_arrived) begin
                r_st.arrived <= 1'b1;
            end
            // Latency counts down regardless of arrival and sticks at zero.
            if (r_st.valid && r_st.cnt != '0) begin
                r_st.cnt <= r_st.cnt - 1'b1;
            end
        end
    end

    assign o_valid    = r_st.valid;
    assign o_id       = r_st.id;
    assign o_eligible = r_st.valid && r_st.arrived && (r_st.cnt == '0) && (r_older == '0);

endmodule

// File: rtl/simmem_release_scheduler.sv
// simmem_release_scheduler: decides when each response held in a simmem
// bank may leave it. One instance per bank (write-response, read-data).
// A slot is releasable once its simulated delay has elapsed, its response
// has arrived, and every older slot with the same AXI ID has been released.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   sched_valid_i/ready_o, sched_addr_i/id_i/delay_i   schedule handshake
//   arrived_onehot_i    bank stored a slot's response
//   release_en_o        multi-hot of slots allowed to leave (state only)
//   released_onehot_i   bank reports a slot released
//   pending_o           slot is tracked
//   stat_released_o, stat_stall_o   only with SIMMEM_RELEASE_STATS_EN defined
// Optional feature macro: SIMMEM_RELEASE_STATS_EN (release/stall counters).
module simmem_release_scheduler
    import simmem_pkg::*;
#(
    parameter  int unsigned NumSlots   = WrNumSlots,
    parameter  int unsigned NumIds     = AxiNumIds,
    parameter  int unsigned DelayWidth = WrDelayWidth,
    localparam int unsigned SlotW      = $clog2(NumSlots),
    localparam int unsigned IdW        = $clog2(NumIds)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sched_valid_i,
    output logic                  sched_ready_o,
    input  logic [SlotW-1:0]      sched_addr_i,
    input  logic [IdW-1:0]        sched_id_i,
    input  logic [DelayWidth-1:0] sched_delay_i,
    input  logic [NumSlots-1:0]   arrived_onehot_i,
    output logic [NumSlots-1:0]   release_en_o,
    input  logic [NumSlots-1:0]   released_onehot_i,
    output logic [NumSlots-1:0]   pending_o
`ifdef SIMMEM_RELEASE_STATS_EN
    ,
    output logic [31:0]           stat_released_o,
    output logic [31:0]           stat_stall_o
`endif
);

    sched_req_t                     w_req;
    logic [NumSlots-1:0]            w_valid;
    logic [NumSlots-1:0]            w_elig;
    logic [NumSlots-1:0][IdW-1:0]   w_id;
    logic [NumSlots-1:0]            w_same;
    logic [NumSlots-1:0]            w_older_in;
    logic [NumSlots-1:0]            w_rel;
    logic                           w_accept;

    assign w_req = '{addr: sched_addr_i, id: sched_id_i, delay: sched_delay_i};

    assign sched_ready_o = ~w_valid[w_req.addr];
    assign w_accept      = sched_valid_i & sched_ready_o;

    // Release reports for slots that are not enabled are dropped.
    assign w_rel = released_onehot_i & w_elig;

    // Same-ID slots still tracked become the new slot's ordering mask;
    // slots leaving this very cycle are excluded.
    always_comb begin
        w_same = '0;
        for (int s = 0; s < NumSlots; s++) begin
            w_same[s] = w_valid[s] && (w_id[s] == w_req.id);
        end
        w_older_in = w_same & ~w_rel;
    end

    for (genvar s = 0; s < NumSlots; s++) begin : g_slot
        simmem_release_slot #(
            .NumSlots (NumSlots)
        ) u_slot (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .i_accept       (w_accept && (w_req.addr == SlotW'(s))),
            .i_id           (w_req.id),
            .i_delay        (w_req.delay),
            .i_arrived      (arrived_onehot_i[s]),
            .i_older        (w_older_in),
            .i_released     (w_rel),
            .i_release_self (w_rel[s]),
            .o_valid        (w_valid[s]),
            .o_id           (w_id[s]),
            .o_eligible     (w_elig[s])
        );
    end

    assign release_en_o = w_elig;
    assign pending_o    = w_valid;

`ifdef SIMMEM_RELEASE_STATS_EN
    logic [31:0] r_stat_released;
    logic [31:0] r_stat_stall;
    logic [31:0] w_pop;

    always_comb begin
        w_pop = '0;
        for (int s = 0; s < NumSlots; s++) begin
            w_pop = w_pop + 32'(released_onehot_i[s]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stat_released <= '0;
            r_stat_stall    <= '0;
        end else begin
            r_stat_released <= r_stat_released + w_pop;
            if ((w_elig != '0) && (released_onehot_i == '0)) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_released_o = r_stat_released;
    assign stat_stall_o    = r_stat_stall;
`endif

    // The bank may only release slots this scheduler has enabled.
    a_release_enabled: assert property (@(posedge clk_i) disable iff (rst_i)
        (released_onehot_i & ~w_elig) == '0);

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Directed bench for simmem_release_scheduler (16 slots, 4 IDs, 8-bit delay).
// Inputs change 1 time unit after a rising edge; outputs are checked in
// that same cycle, once the registered state has settled.
module tb_simmem_release_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        sched_valid_i = 1'b0;
    logic        sched_ready_o;
    logic [3:0]  sched_addr_i = '0;
    logic [1:0]  sched_id_i = '0;
    logic [7:0]  sched_delay_i = '0;
    logic [15:0] arrived_onehot_i = '0;
    logic [15:0] release_en_o;
    logic [15:0] released_onehot_i = '0;
    logic [15:0] pending_o;
`ifdef SIMMEM_RELEASE_STATS_EN
    logic [31:0] stat_released_o;
    logic [31:0] stat_stall_o;
`endif

    int total = 0;
    int bad   = 0;

    simmem_release_scheduler dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .sched_valid_i     (sched_valid_i),
        .sched_ready_o     (sched_ready_o),
        .sched_addr_i      (sched_addr_i),
        .sched_id_i        (sched_id_i),
        .sched_delay_i     (sched_delay_i),
        .arrived_onehot_i  (arrived_onehot_i),
        .release_en_o      (release_en_o),
        .released_onehot_i (released_onehot_i),
        .pending_o         (pending_o)
`ifdef SIMMEM_RELEASE_STATS_EN
        ,
        .stat_released_o   (stat_released_o),
        .stat_stall_o      (stat_stall_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Present a schedule request (plus optional arrivals) for one cycle.
    task automatic accept(input logic [3:0] a, input logic [1:0] id,
                          input logic [7:0] d, input logic [15:0] arr);
        sched_valid_i    = 1'b1;
        sched_addr_i     = a;
        sched_id_i       = id;
        sched_delay_i    = d;
        arrived_onehot_i = arr;
        cyc();
        sched_valid_i    = 1'b0;
        arrived_onehot_i = '0;
    endtask

    task automatic release_slots(input logic [15:0] m);
        released_onehot_i = m;
        cyc();
        released_onehot_i = '0;
    endtask

    task automatic rdy(input string tag, input logic [3:0] a, input logic exp);
        sched_addr_i = a;
        #1;
        chk(tag, 32'(sched_ready_o), 32'(exp));
    endtask

    initial begin
        // Reset
        repeat (2) cyc();
        rst_i = 1'b0;
        chk("rst_release_en", 32'(release_en_o), 32'h0);
        chk("rst_pending", 32'(pending_o), 32'h0);
        rdy("rst_ready", 4'd0, 1'b1);

        // delay 0, same-cycle arrival -> enabled next cycle
        accept(4'd3, 2'd1, 8'd0, 16'h0008);
        chk("d0_release_en", 32'(release_en_o), 32'h0008);
        chk("d0_pending", 32'(pending_o), 32'h0008);
        rdy("d0_ready_busy", 4'd3, 1'b0);
        release_slots(16'h0008);
        chk("d0_after_rel", 32'(release_en_o), 32'h0);
        chk("d0_pending_clr", 32'(pending_o), 32'h0);
        rdy("d0_ready_free", 4'd3, 1'b1);

        // delay 5, arrival one cycle after accept -> high at accept+6
        accept(4'd2, 2'd2, 8'd5, 16'h0);
        arrived_onehot_i = 16'h0004;
        chk("d5_t1", 32'(release_en_o), 32'h0);
        cyc();
        arrived_onehot_i = '0;
        for (int k = 0; k < 4; k++) begin
            chk("d5_wait", 32'(release_en_o), 32'h0);
            cyc();
        end
        chk("d5_t6", 32'(release_en_o), 32'h0004);
        release_slots(16'h0004);
        chk("d5_after_rel", 32'(pending_o), 32'h0);

        // same ID: slot 5 waits behind slot 4
        accept(4'd4, 2'd0, 8'd10, 16'h0010);
        accept(4'd5, 2'd0, 8'd0, 16'h0020);
        chk("ord_t2", 32'(release_en_o), 32'h0);
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("ord_wait", 32'(release_en_o), 32'h0);
        end
        cyc();
        chk("ord_slot4_en", 32'(release_en_o), 32'h0010);
        release_slots(16'h0010);
        chk("ord_slot5_en", 32'(release_en_o), 32'h0020);
        chk("ord_pending", 32'(pending_o), 32'h0020);
        release_slots(16'h0020);
        chk("ord_done", 32'(pending_o), 32'h0);

        // different IDs are independent
        accept(4'd6, 2'd1, 8'd8, 16'h0040);
        accept(4'd7, 2'd2, 8'd0, 16'h0080);
        chk("ind_slot7_en", 32'(release_en_o), 32'h0080);
        release_slots(16'h0080);
        chk("ind_after7", 32'(release_en_o), 32'h0);
        chk("ind_pending6", 32'(pending_o), 32'h0040);
        repeat (5) cyc();
        chk("ind_slot6_early", 32'(release_en_o), 32'h0);
        cyc();
        chk("ind_slot6_en", 32'(release_en_o), 32'h0040);
        release_slots(16'h0040);
        chk("ind_done", 32'(pending_o), 32'h0);

        // fill the bank; slot 9 alone uses id 3 so it has no older slot
        for (int a = 0; a < 16; a++) begin
            accept(4'(a), (a == 9) ? 2'd3 : 2'(a % 3), 8'd0, 16'h0);
        end
        chk("full_pending", 32'(pending_o), 32'hffff);
        for (int a = 0; a < 16; a++) begin
            rdy("full_ready", 4'(a), 1'b0);
        end
        arrived_onehot_i = 16'h0200;
        cyc();
        arrived_onehot_i = '0;
        chk("full_slot9_en", 32'(release_en_o), 32'h0200);
        release_slots(16'h0200);
        rdy("full_ready9", 4'd9, 1'b1);
        rdy("full_ready8", 4'd8, 1'b0);
        chk("full_pending9", 32'(pending_o), 32'hfdff);

        // reset mid-operation drops everything
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        chk("midrst_pending", 32'(pending_o), 32'h0);
        chk("midrst_release_en", 32'(release_en_o), 32'h0);

`ifdef SIMMEM_RELEASE_STATS_EN
        chk("stat_rst_released", stat_released_o, 32'd0);
        chk("stat_rst_stall", stat_stall_o, 32'd0);
        accept(4'd0, 2'd0, 8'd1, 16'h0001);
        accept(4'd1, 2'd1, 8'd0, 16'h0002);
        chk("stat_both_en", 32'(release_en_o), 32'h0003);
        repeat (3) cyc();
        release_slots(16'h0003);
        chk("stat_stall", stat_stall_o, 32'd3);
        chk("stat_released", stat_released_o, 32'd2);
        chk("stat_after_rel", 32'(release_en_o), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
